// File: rtl/prbs_pkg.sv
// Shared constants for the PRBS generator: mode encodings, polynomial degree/tap per mode
// and the all-ones value used to escape the LFSR lock-up state.
package prbs_pkg;

    typedef enum logic [1:0] {
        PRBS7  = 2'd0,
        PRBS15 = 2'd1,
        PRBS23 = 2'd2,
        PRBS31 = 2'd3
    } prbs_mode_e;

    localparam int          LFSR_W    = 31;
    localparam logic [30:0] LFSR_ONES = 31'h7FFF_FFFF;

    function automatic logic [4:0] prbs_deg(input logic [1:0] m);
        case (prbs_mode_e'(m))
            PRBS7:   prbs_deg = 5'd7;
            PRBS15:  prbs_deg = 5'd15;
            PRBS23:  prbs_deg = 5'd23;
            PRBS31:  prbs_deg = 5'd31;
            default: prbs_deg = 5'd31;
        endcase
    endfunction

    function automatic logic [4:0] prbs_tap(input logic [1:0] m);
        case (prbs_mode_e'(m))
            PRBS7:   prbs_tap = 5'd6;
            PRBS15:  prbs_tap = 5'd14;
            PRBS23:  prbs_tap = 5'd18;
            PRBS31:  prbs_tap = 5'd28;
            default: prbs_tap = 5'd28;
        endcase
    endfunction

    // Live-bit mask of the state register; also the reset/lock-up replacement value.
    function automatic logic [30:0] prbs_mask(input logic [1:0] m);
        case (prbs_mode_e'(m))
            PRBS7:   prbs_mask = 31'h0000_007F;
            PRBS15:  prbs_mask = 31'h0000_7FFF;
            PRBS23:  prbs_mask = 31'h007F_FFFF;
            PRBS31:  prbs_mask = LFSR_ONES;
            default: prbs_mask = LFSR_ONES;
        endcase
    endfunction

endpackage

// File: rtl/prbs_gen_inj_lfsr_step.sv
// Combinational DATA_W-step Fibonacci LFSR advance; the first generated bit lands in the MSB.
// Unused high state bits are masked to zero on entry and exit.
module prbs_lfsr_step
    import prbs_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [30:0]       state_in,
    input  logic [1:0]        mode,
    output logic [30:0]       state_out,
    output logic [DATA_W-1:0] bits_out
);

    logic [30:0] msk_s;
    logic [4:0]  deg_s;
    logic [4:0]  tap_s;

    // Unrolled shift: new bit = s[L-1] ^ s[T-1], shifted in at the bottom.
    always_comb begin
        logic [30:0] st;
        logic        nb;
        msk_s    = prbs_mask(mode);
        deg_s    = prbs_deg(mode);
        tap_s    = prbs_tap(mode);
        bits_out = '0;
        st       = state_in & msk_s;
        nb       = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            nb                    = st[deg_s - 5'd1] ^ st[tap_s - 5'd1];
            st                    = {st[29:0], nb} & msk_s;
            bits_out[DATA_W-1-i]  = nb;
        end
        state_out = st;
    end

endmodule

// File: rtl/prbs_gen_inj.sv
// Parallel PRBS7/15/23/31 source with valid/ready output, periodic or single-shot bit-0
// error injection (data only, LFSR untouched) and a saturating injected-word counter.
module prbs_gen_inj
    import prbs_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int INJ_CNT_W = 30,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic                 seed_load,
    input  logic [30:0]          seed,
    input  logic                 inj_en,
    input  logic [INJ_CNT_W-1:0] inj_period,
    input  logic                 inj_single,
    output logic [DATA_W-1:0]    dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic [30:0]          lfsr_q, lfsr_d;
    logic [1:0]           mode_q, mode_d;
    logic                 mode_vld_q, mode_vld_d;
    logic [DATA_W-1:0]    dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic [INJ_CNT_W-1:0] inj_cnt_q, inj_cnt_d;
    logic                 pend_q, pend_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;

    logic [30:0]          step_state_s;
    logic [DATA_W-1:0]    step_bits_s;
    logic [30:0]          seed_m_s;
    logic                 mode_chg_s, accept_s, load_s, per_hit_s, flip_s;

    prbs_lfsr_step #(.DATA_W(DATA_W)) u_step (
        .state_in  (lfsr_q),
        .mode      (mode),
        .state_out (step_state_s),
        .bits_out  (step_bits_s)
    );

    // Flow control, LFSR update priority and injection bookkeeping.
    always_comb begin
        // mode_vld_q keeps the first post-reset cycle from looking like a mode change
        mode_chg_s = mode_vld_q & (mode != mode_q);
        accept_s   = dout_valid_q & dout_ready;
        load_s     = en & (~dout_valid_q | accept_s) & ~seed_load & ~mode_chg_s;
        per_hit_s  = inj_en & (inj_cnt_q == inj_period);
        flip_s     = per_hit_s | pend_q | inj_single;
        seed_m_s   = seed & prbs_mask(mode);
        mode_d     = mode;
        mode_vld_d = 1'b1;

        if (mode_chg_s) begin
            lfsr_d = prbs_mask(mode);
        end else if (seed_load) begin
            lfsr_d = (seed_m_s == 31'd0) ? prbs_mask(mode) : seed_m_s;
        end else if (load_s) begin
            lfsr_d = step_state_s;
        end else begin
            lfsr_d = lfsr_q;
        end

        if (load_s) begin
            dout_d       = step_bits_s ^ {{(DATA_W-1){1'b0}}, flip_s};
            dout_valid_d = 1'b1;
        end else if (accept_s) begin
            dout_d       = dout_q;
            dout_valid_d = 1'b0;
        end else begin
            dout_d       = dout_q;
            dout_valid_d = dout_valid_q;
        end

        if (!inj_en) begin
            inj_cnt_d = '0;
        end else if (load_s) begin
            inj_cnt_d = per_hit_s ? '0 : inj_cnt_q + {{(INJ_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            inj_cnt_d = inj_cnt_q;
        end

        if (load_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q | inj_single;
        end

        if (load_s && flip_s && (err_q != {ERR_CNT_W{1'b1}})) begin
            err_d = err_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_d = err_q;
        end
    end

    // State registers; an asserted reset drops any pending output word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q       <= LFSR_ONES;
            mode_q       <= 2'd0;
            mode_vld_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            inj_cnt_q    <= '0;
            pend_q       <= 1'b0;
            err_q        <= '0;
        end else begin
            lfsr_q       <= lfsr_d;
            mode_q       <= mode_d;
            mode_vld_q   <= mode_vld_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            inj_cnt_q    <= inj_cnt_d;
            pend_q       <= pend_d;
            err_q        <= err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_prbs_gen_inj.sv
// Directed bench for prbs_gen_inj (DATA_W=7): a serial golden LFSR fills a scoreboard queue,
// accepted words are popped and compared.
module tb_prbs_gen_inj;

    localparam int DW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic          seed_load;
    logic [30:0]   seed;
    logic          inj_en;
    logic [29:0]   inj_period;
    logic          inj_single;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [15:0]   err_count;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got[$];

    bit [30:0] m_st;
    bit [30:0] m_msk;
    int        m_deg;
    int        m_tap;

    always #5 clk = ~clk;

    prbs_gen_inj #(.DATA_W(DW), .INJ_CNT_W(30), .ERR_CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .seed_load  (seed_load),
        .seed       (seed),
        .inj_en     (inj_en),
        .inj_period (inj_period),
        .inj_single (inj_single),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .err_count  (err_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset(input int md);
        case (md)
            0:       begin m_deg = 7;  m_tap = 6;  end
            1:       begin m_deg = 15; m_tap = 14; end
            2:       begin m_deg = 23; m_tap = 18; end
            default: begin m_deg = 31; m_tap = 28; end
        endcase
        m_msk = 31'h7FFF_FFFF >> (31 - m_deg);
        m_st  = m_msk;
    endfunction

    function automatic logic [DW-1:0] m_next();
        logic [DW-1:0] w;
        bit            nb;
        w = '0;
        for (int i = 0; i < DW; i++) begin
            nb = m_st[m_deg-1] ^ m_st[m_tap-1];
            m_st = {m_st[29:0], nb} & m_msk;
            w[DW-1-i] = nb;
        end
        return w;
    endfunction

    function automatic void push(input int n, input bit flip);
        for (int i = 0; i < n; i++) exp_q.push_back(m_next() ^ {6'd0, flip});
    endfunction

    // Called at a negedge; accepts n words, then stalls so the next word stays held.
    task automatic drain(input int n, input string tag);
        int cnt;
        int cyc;
        logic [DW-1:0] e;
        cnt = 0;
        cyc = 0;
        dout_ready = 1'b1;
        while (cnt < n && cyc < n * 4 + 20) begin
            if (dout_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 7'h00;
                chk(tag, dout, e);
                got.push_back(dout);
                cnt++;
            end
            if (cnt < n) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (cnt < n) chk({tag, "_timeout"}, cnt, n);
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] hold;
        bit            seen[128];
        int            uniq;
        int            cyc;

        rst = 1'b1; en = 1'b0; mode = 2'd0; seed_load = 1'b0; seed = 31'd0;
        inj_en = 1'b0; inj_period = 30'd0; inj_single = 1'b0; dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 7'd0);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_err", err_count, 16'd0);

        // Cold start, PRBS7: latency, period 127, distinctness
        rst = 1'b0; en = 1'b1;
        @(negedge clk);
        chk("first_valid_latency", dout_valid, 1'b1);
        m_reset(0);
        got.delete();
        push(137, 1'b0);
        drain(137, "prbs7");
        for (int k = 0; k < 10; k++) chk("prbs7_period", got[k+127], got[k]);
        uniq = 0;
        for (int k = 0; k < 127; k++) begin
            if (!seen[got[k]]) uniq++;
            seen[got[k]] = 1'b1;
        end
        chk("prbs7_distinct", uniq, 127);

        // Stall: held word and valid stable for 5 clocks, no skipped words afterwards
        hold = dout;
        repeat (5) begin
            @(negedge clk);
            chk("stall_dout", dout, hold);
            chk("stall_valid", dout_valid, 1'b1);
        end
        push(21, 1'b0);
        drain(21, "after_stall");

        // Periodic injection every 10th word
        inj_en = 1'b1; inj_period = 30'd9;
        push(1, 1'b0);
        for (int j = 0; j < 100; j++) push(1, (j % 10) == 9);
        drain(101, "periodic_inj");
        chk("periodic_err", err_count, 16'd10);
        inj_en = 1'b0;

        // Single and periodic on the same words: one flip each, pending cleared
        @(negedge clk);
        inj_en = 1'b1; inj_period = 30'd0; inj_single = 1'b1;
        @(negedge clk);
        inj_single = 1'b0;
        push(1, 1'b0);
        push(3, 1'b1);
        drain(4, "single_plus_periodic");
        chk("coincide_err", err_count, 16'd14);
        inj_en = 1'b0;
        push(1, 1'b1);
        push(3, 1'b0);
        drain(4, "pending_cleared");
        chk("pending_err", err_count, 16'd14);

        // Single-shot alone
        inj_single = 1'b1;
        @(negedge clk);
        inj_single = 1'b0;
        push(1, 1'b0);
        push(1, 1'b1);
        push(2, 1'b0);
        drain(4, "single_inj");
        chk("single_err", err_count, 16'd15);

        // Mode change to PRBS31, then seed reloads
        push(1, 1'b0);
        mode = 2'd3;
        @(negedge clk);
        m_reset(3);
        push(10, 1'b0);
        drain(11, "prbs31_modechg");
        seed_load = 1'b1; seed = 31'd0;
        @(negedge clk);
        seed_load = 1'b0;
        push(1, 1'b0);
        m_reset(3);
        push(10, 1'b0);
        drain(11, "prbs31_seed0");
        seed_load = 1'b1; seed = 31'h5A5A_1234;
        @(negedge clk);
        seed_load = 1'b0;
        push(1, 1'b0);
        m_st = 31'h5A5A_1234 & m_msk;
        push(10, 1'b0);
        drain(11, "prbs31_seed");

        // Saturate the error counter
        inj_en = 1'b1; inj_period = 30'd0; dout_ready = 1'b1;
        cyc = 0;
        while (err_count !== 16'hFFFF && cyc < 70000) begin
            @(negedge clk);
            cyc++;
        end
        chk("err_reach_max", err_count, 16'hFFFF);
        repeat (5) @(negedge clk);
        chk("err_saturated", err_count, 16'hFFFF);
        chk("sat_valid", dout_valid, 1'b1);
        exp_q.delete();

        // Mid-run reset while valid, then restart must match a cold start
        rst = 1'b1;
        #1;
        chk("midrst_dout", dout, 7'd0);
        chk("midrst_valid", dout_valid, 1'b0);
        chk("midrst_err", err_count, 16'd0);
        inj_en = 1'b0; mode = 2'd0; dout_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_valid", dout_valid, 1'b1);
        m_reset(0);
        push(20, 1'b0);
        drain(20, "restart");
        chk("restart_err", err_count, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
